settings_bus_initiator: RTL and testbench

SETTINGS_BUS_INITIATOR -- requirements
Module: settings_bus_initiator

---
 rtl/settings_bus_initiator.sv | 150 +++++++++++++++
 tb/tb_settings_bus_initiator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/settings_bus_initiator.sv
// settings_bus_initiator
// Queues settings-register write commands in a small FIFO and issues them on
// a settings bus as single-cycle write strobes, in acceptance order, with an
// optional minimum idle spacing between strobes.
//
// Parameters
//   DEPTH_LOG2 : FIFO depth is 2**DEPTH_LOG2 commands (must be >= 1)
//   GAP        : minimum idle cycles between consecutive set_stb pulses (0..255)
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst_n      : synchronous active-low reset
//   clear      : synchronous flush of queued commands and pending gap
//   in_valid   : command present on in_addr/in_data
//   in_ready   : command can be accepted this cycle
//   in_addr    : command register address (8 bits)
//   in_data    : command write data (32 bits)
//   set_stb    : settings bus write strobe, one cycle per command
//   set_addr   : settings bus address, holds last issued value
//   set_data   : settings bus data, holds last issued value
//   count      : commands currently queued (0..DEPTH)
//   busy       : queue non-empty, strobe active, or gap hold active
//   fsm_state  : debug view of the issue FSM (0 IDLE, 1 ISSUE, 2 HOLD)
//
// Handshake: a command transfers on a rising edge where in_valid && in_ready.
// in_ready is combinational (not in reset, not clearing, FIFO not full) and
// never depends on in_valid; the source may hold in_valid until accepted.
module settings_bus_initiator #(
  parameter int DEPTH_LOG2 = 2,
  parameter int GAP        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_addr,
  input  logic [31:0]           in_data,
  output logic                  set_stb,
  output logic [7:0]            set_addr,
  output logic [31:0]           set_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [39:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [1:0]          state;
  logic [7:0]          gap_cnt;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;

  // Extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign in_ready  = rst_n && !clear && !full;
  assign push      = in_valid && in_ready;
  assign busy      = !empty || set_stb || (state == HOLD);
  assign fsm_state = state;

  // A pop loads the output registers, so it is exactly the next-cycle strobe.
  // With GAP=0 ISSUE keeps popping to give one command per clock.
  always_comb begin
    pop = 1'b0;
    if (rst_n && !clear && !empty) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if ((state == ISSUE) && (GAP == 0)) begin
        pop = 1'b1;
      end
    end
  end

  // Storage has no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {in_addr, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= IDLE;
      gap_cnt  <= 8'd0;
      set_stb  <= 1'b0;
      set_addr <= 8'd0;
      set_data <= 32'd0;
    end else if (clear) begin
      // Flush wins over any push or pop; the bus values are left as they were.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      state   <= IDLE;
      gap_cnt <= 8'd0;
      set_stb <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        set_addr <= mem[rd_ptr[DEPTH_LOG2-1:0]][39:32];
        set_data <= mem[rd_ptr[DEPTH_LOG2-1:0]][31:0];
      end
      set_stb <= pop;

      case (state)
        IDLE: begin
          if (pop) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (GAP == 0) begin
            state <= pop ? ISSUE : IDLE;
          end else begin
            gap_cnt <= 8'(GAP);
            state   <= HOLD;
          end
        end
        HOLD: begin
          // The strobe cycle after HOLD comes from IDLE, which itself is a
          // low cycle, so HOLD is left when the count is about to reach 1.
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt <= 8'd2) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_settings_bus_initiator.sv
// Bench for settings_bus_initiator: one instance with GAP=0 and one with
// GAP=2 share the stimulus. A transaction-level model per instance predicts
// the strobe stream, counts and flags every cycle.
module tb_settings_bus_initiator;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_addr;
  logic [31:0] in_data;

  logic        in_ready0, set_stb0, busy0;
  logic [7:0]  set_addr0;
  logic [31:0] set_data0;
  logic [2:0]  count0;
  logic [1:0]  fsm_state0;

  logic        in_ready2, set_stb2, busy2;
  logic [7:0]  set_addr2;
  logic [31:0] set_data2;
  logic [2:0]  count2;
  logic [1:0]  fsm_state2;

  settings_bus_initiator #(.DEPTH_LOG2(2), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready0), .in_addr(in_addr), .in_data(in_data),
    .set_stb(set_stb0), .set_addr(set_addr0), .set_data(set_data0),
    .count(count0), .busy(busy0), .fsm_state(fsm_state0)
  );

  settings_bus_initiator #(.DEPTH_LOG2(2), .GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready2), .in_addr(in_addr), .in_data(in_data),
    .set_stb(set_stb2), .set_addr(set_addr2), .set_data(set_data2),
    .count(count2), .busy(busy2), .fsm_state(fsm_state2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [39:0] exp_q [2][$];   // commands accepted but not yet issued
  logic        m_stb  [2];
  logic [7:0]  m_addr [2];
  logic [31:0] m_data [2];
  int          m_last [2];     // cycle of last strobe, -1 when none pending
  int          m_gap  [2];

  int          st_cyc0[$], st_cyc2[$];
  logic [7:0]  st_addr0[$];
  logic        rdy0_pre, rdy2_pre;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One rising edge of the specified behaviour for instance k.
  task automatic model_edge(input int k, input logic r, input logic c,
                            input logic v, input logic [7:0] a, input logic [31:0] d);
    int s;
    logic [39:0] e;
    s = exp_q[k].size();
    if (!r) begin
      exp_q[k].delete();
      m_stb[k] = 1'b0; m_addr[k] = 8'd0; m_data[k] = 32'd0; m_last[k] = -1;
    end else if (c) begin
      exp_q[k].delete();
      m_stb[k] = 1'b0; m_last[k] = -1;
    end else begin
      if (s > 0 && (m_last[k] < 0 || cyc - m_last[k] - 1 >= m_gap[k])) begin
        e = exp_q[k].pop_front();
        m_stb[k] = 1'b1; m_addr[k] = e[39:32]; m_data[k] = e[31:0];
        m_last[k] = cyc;
      end else begin
        m_stb[k] = 1'b0;
      end
      if (v && s < DEPTH) exp_q[k].push_back({a, d});
    end
  endtask

  task automatic model_cmp(input int k, input logic stb, input logic [7:0] a,
                           input logic [31:0] d, input logic [2:0] cnt, input logic bsy);
    logic hold;
    hold = (m_gap[k] > 0) && (m_last[k] >= 0) &&
           (cyc - m_last[k] >= 1) && (cyc - m_last[k] <= m_gap[k] - 1);
    chk($sformatf("stb%0d", k), stb, m_stb[k]);
    chk($sformatf("addr%0d", k), a, m_addr[k]);
    chk($sformatf("data%0d", k), d, m_data[k]);
    chk($sformatf("count%0d", k), cnt, exp_q[k].size());
    chk($sformatf("busy%0d", k), bsy, (exp_q[k].size() > 0) || m_stb[k] || hold);
  endtask

  // Drive inputs (called just after a falling edge), check the combinational
  // ready, take one rising edge, then check registered outputs.
  task automatic step(input logic r, input logic c, input logic v,
                      input logic [7:0] a, input logic [31:0] d);
    rst_n = r; clear = c; in_valid = v; in_addr = a; in_data = d;
    #1;
    rdy0_pre = in_ready0;
    rdy2_pre = in_ready2;
    chk("ready0", in_ready0, r && !c && (exp_q[0].size() < DEPTH));
    chk("ready2", in_ready2, r && !c && (exp_q[1].size() < DEPTH));
    @(posedge clk);
    cyc++;
    model_edge(0, r, c, v, a, d);
    model_edge(1, r, c, v, a, d);
    #1;
    model_cmp(0, set_stb0, set_addr0, set_data0, count0, busy0);
    model_cmp(1, set_stb2, set_addr2, set_data2, count2, busy2);
    if (set_stb0) begin st_cyc0.push_back(cyc); st_addr0.push_back(set_addr0); end
    if (set_stb2) st_cyc2.push_back(cyc);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  typedef struct {
    logic        r, c, v;
    logic [7:0]  a;
    logic [31:0] d;
    logic        exp_ready, exp_stb;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    logic [2:0]  exp_count;
    logic        exp_busy;
  } vec_t;

  vec_t vec [11];

  initial begin
    m_gap[0] = 0; m_gap[1] = 2;
    for (int k = 0; k < 2; k++) begin
      m_stb[k] = 1'b0; m_addr[k] = 8'd0; m_data[k] = 32'd0; m_last[k] = -1;
    end
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_addr = 8'd0; in_data = 32'd0;
    @(negedge clk);

    // Reset, with a command offered that must be refused.
    step(1'b0, 1'b0, 1'b1, 8'hAA, 32'h1234);
    step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    chk("reset_stb", set_stb0, 1'b0);
    chk("reset_count", count0, 3'd0);
    chk("reset_ready_low", rdy0_pre, 1'b0);

    // Table: single write, boundary back-to-back pair, clear, reset (GAP=0).
    //          r     c     v     addr   data           rdy   stb   addr   data           cnt   busy
    vec[0]  = '{1'b1, 1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 32'h00000000, 3'd1, 1'b1};
    vec[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b1, 8'h05, 32'hDEADBEEF, 3'd0, 1'b1};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 8'h05, 32'hDEADBEEF, 3'd0, 1'b0};
    vec[3]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF, 1'b1, 1'b0, 8'h05, 32'hDEADBEEF, 3'd1, 1'b1};
    vec[4]  = '{1'b1, 1'b0, 1'b1, 8'h00, 32'h00000000, 1'b1, 1'b1, 8'hFF, 32'hFFFFFFFF, 3'd1, 1'b1};
    vec[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b1, 8'h00, 32'h00000000, 3'd0, 1'b1};
    vec[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 8'h00, 32'h00000000, 3'd0, 1'b0};
    vec[7]  = '{1'b1, 1'b1, 1'b1, 8'h11, 32'h11111111, 1'b0, 1'b0, 8'h00, 32'h00000000, 3'd0, 1'b0};
    vec[8]  = '{1'b1, 1'b0, 1'b1, 8'h22, 32'h22222222, 1'b1, 1'b0, 8'h00, 32'h00000000, 3'd1, 1'b1};
    vec[9]  = '{1'b0, 1'b0, 1'b1, 8'h33, 32'h33333333, 1'b0, 1'b0, 8'h00, 32'h00000000, 3'd0, 1'b0};
    vec[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 8'h00, 32'h00000000, 3'd0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      step(vec[i].r, vec[i].c, vec[i].v, vec[i].a, vec[i].d);
      chk($sformatf("vec%0d_ready", i), rdy0_pre, vec[i].exp_ready);
      chk($sformatf("vec%0d_stb", i), set_stb0, vec[i].exp_stb);
      chk($sformatf("vec%0d_addr", i), set_addr0, vec[i].exp_addr);
      chk($sformatf("vec%0d_data", i), set_data0, vec[i].exp_data);
      chk($sformatf("vec%0d_count", i), count0, vec[i].exp_count);
      chk($sformatf("vec%0d_busy", i), busy0, vec[i].exp_busy);
    end

    // Three queued commands: GAP=2 gives exactly two low cycles between pulses.
    st_cyc0.delete(); st_cyc2.delete(); st_addr0.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'h31 + 8'(i), 32'h3100 + i);
    idle(10);
    chk("gap2_pulses", st_cyc2.size(), 3);
    chk("gap0_pulses", st_cyc0.size(), 3);
    if (st_cyc2.size() == 3) begin
      chk("gap2_spacing_a", st_cyc2[1] - st_cyc2[0], 3);
      chk("gap2_spacing_b", st_cyc2[2] - st_cyc2[1], 3);
    end

    // Burst of six with in_valid held: GAP=0 issues one per clock, GAP=2 fills.
    st_cyc0.delete(); st_addr0.delete();
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 32'h600 + i);
    chk("burst_full_count2", count2, 3'd4);
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    chk("burst_full_ready2", rdy2_pre, 1'b0);
    idle(14);
    chk("burst_pulses0", st_cyc0.size(), 6);
    if (st_cyc0.size() == 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("burst_addr%0d", i), st_addr0[i], 8'(i + 1));
      chk("burst_consecutive", st_cyc0[5] - st_cyc0[0], 5);
    end
    chk("burst_drained2", count2, 3'd0);

    // Clear with three commands queued after the first strobe.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'h41 + 8'(i), 32'h4100 + i);
    chk("preclear_count2", count2, 3'd3);
    st_cyc2.delete();
    step(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
    chk("clear_count2", count2, 3'd0);
    chk("clear_stb2", set_stb2, 1'b0);
    chk("clear_addr_hold2", set_addr2, 8'h41);
    idle(8);
    chk("clear_ready2", rdy2_pre, 1'b1);
    chk("clear_no_strobes", st_cyc2.size(), 0);

    // Reset mid-burst, then a fresh command obeys the two-edge latency.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'h51 + 8'(i), 32'h5100 + i);
    step(1'b0, 1'b0, 1'b1, 8'h54, 32'h5400);
    chk("rst_addr2", set_addr2, 8'h00);
    chk("rst_count2", count2, 3'd0);
    st_cyc0.delete(); st_cyc2.delete();
    idle(6);
    chk("rst_no_strobes", st_cyc0.size() + st_cyc2.size(), 0);
    step(1'b1, 1'b0, 1'b1, 8'h61, 32'hCAFEF00D);
    chk("lat_not_yet", set_stb0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    chk("lat_stb0", set_stb0, 1'b1);
    chk("lat_stb2", set_stb2, 1'b1);
    chk("lat_data0", set_data0, 32'hCAFEF00D);
    idle(4);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 70), 8'($urandom), $urandom);
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
